// File: rtl/shift_add_multiplier_if.sv
// shift_add_multiplier_if: START/AVAIL handshake and operand/result bus for the shift-and-add multiplier
interface shift_add_multiplier_if #(parameter int WL = 4);
    logic            START;
    logic [WL-1:0]   MULTIPLICAND;
    logic [WL-1:0]   MULTIPLIER;
    logic [2*WL-1:0] PRODUCT;
    logic            BUSY;
    logic            AVAIL;
    modport master (output START, MULTIPLICAND, MULTIPLIER, input PRODUCT, BUSY, AVAIL);
    modport slave  (input START, MULTIPLICAND, MULTIPLIER, output PRODUCT, BUSY, AVAIL);
endinterface

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned shift-and-add multiplier, one add-and-shift step per clock
module shift_add_multiplier #(parameter int WL = 4) (
    input logic                   CLK,
    input logic                   RST_N,
    shift_add_multiplier_if.slave bus
);
    localparam int CW = $clog2(WL + 1);
    localparam logic [CW-1:0] LAST = CW'(WL - 1);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    state_t          state, state_nxt;
    logic [WL-1:0]   mcand, mplr;
    logic [WL:0]     acc, sum;
    logic [CW-1:0]   cnt;
    logic [2*WL:0]   shifted;
    logic [2*WL-1:0] product;
    logic            accept, last;
    // State register; reset aborts any multiplication in flight
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end
    // Next state: START is honoured only from IDLE or DONE; unused encodings fall back to IDLE
    always_comb begin
        state_nxt = IDLE;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                accept    = bus.START;
                state_nxt = bus.START ? RUN : IDLE;
            end
            RUN: begin
                last      = (cnt == LAST);
                state_nxt = last ? DONE : RUN;
            end
            DONE: begin
                accept    = bus.START;
                state_nxt = bus.START ? RUN : DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end
    // One iteration: conditionally add the multiplicand into the high half, then shift the pair right
    always_comb begin
        sum     = acc + (mplr[0] ? {1'b0, mcand} : '0);
        shifted = {sum, mplr} >> 1;
    end
    // Datapath registers; PRODUCT only changes on the final step so the old result stays visible
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mcand   <= '0;
            mplr    <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (accept) begin
            mcand <= bus.MULTIPLICAND;
            mplr  <= bus.MULTIPLIER;
            acc   <= '0;
            cnt   <= '0;
        end else if (state == RUN) begin
            acc  <= shifted[2*WL:WL];
            mplr <= shifted[WL-1:0];
            cnt  <= cnt + 1'b1;
            if (last) product <= shifted[2*WL-1:0];
        end
    end
    assign bus.PRODUCT = product;
    assign bus.BUSY    = (state == RUN);
    assign bus.AVAIL   = (state == DONE);
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed and randomised checks of the shift-and-add multiplier at WL=4 and WL=8
module tb_shift_add_multiplier;
    logic CLK = 1'b0;
    logic RST_N = 1'b1;
    int   checks = 0;
    int   errors = 0;
    shift_add_multiplier_if #(.WL(4)) m4 ();
    shift_add_multiplier_if #(.WL(8)) m8 ();
    shift_add_multiplier #(.WL(4)) u4 (.CLK(CLK), .RST_N(RST_N), .bus(m4));
    shift_add_multiplier #(.WL(8)) u8 (.CLK(CLK), .RST_N(RST_N), .bus(m8));
    always #5 CLK = ~CLK;
    task automatic tick;
        @(posedge CLK);
        #1;
    endtask
    task automatic check_idle(input string tag);
        checks++;
        if (m4.PRODUCT !== 8'd0 || m4.BUSY !== 1'b0 || m4.AVAIL !== 1'b0 ||
            m8.PRODUCT !== 16'd0 || m8.BUSY !== 1'b0 || m8.AVAIL !== 1'b0) begin
            errors++;
            $display("FAIL %s: p4=%0d b4=%b a4=%b p8=%0d b8=%b a8=%b, want all 0",
                     tag, m4.PRODUCT, m4.BUSY, m4.AVAIL, m8.PRODUCT, m8.BUSY, m8.AVAIL);
        end
    endtask
    // hold: 0 drop START after accept, 1 keep START high in RUN but drop before final edge, 2 keep START high
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp,
                        input string tag, input int hold);
        logic [7:0] old;
        old = m4.PRODUCT;
        m4.START = 1'b1;
        m4.MULTIPLICAND = a;
        m4.MULTIPLIER = b;
        tick();
        m4.START = (hold != 0);
        m4.MULTIPLICAND = 4'd1;
        m4.MULTIPLIER = 4'd1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (m4.BUSY !== 1'b1 || m4.AVAIL !== 1'b0 || m4.PRODUCT !== old) begin
                errors++;
                $display("FAIL %s_run%0d: busy=%b avail=%b product=%0d, want busy=1 avail=0 product=%0d",
                         tag, i, m4.BUSY, m4.AVAIL, m4.PRODUCT, old);
            end
            if (hold == 1 && i == 3) m4.START = 1'b0;
            tick();
        end
        checks++;
        if (m4.AVAIL !== 1'b1 || m4.BUSY !== 1'b0 || m4.PRODUCT !== exp) begin
            errors++;
            $display("FAIL %s_done: avail=%b busy=%b product=%0d, want avail=1 busy=0 product=%0d",
                     tag, m4.AVAIL, m4.BUSY, m4.PRODUCT, exp);
        end
    endtask
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp, input string tag);
        m8.START = 1'b1;
        m8.MULTIPLICAND = a;
        m8.MULTIPLIER = b;
        tick();
        m8.START = 1'b0;
        m8.MULTIPLICAND = ~a;
        m8.MULTIPLIER = ~b;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (m8.BUSY !== 1'b1 || m8.AVAIL !== 1'b0) begin
                errors++;
                $display("FAIL %s_run%0d: busy=%b avail=%b, want busy=1 avail=0", tag, i, m8.BUSY, m8.AVAIL);
            end
            tick();
        end
        checks++;
        if (m8.AVAIL !== 1'b1 || m8.BUSY !== 1'b0 || m8.PRODUCT !== exp) begin
            errors++;
            $display("FAIL %s_done a=%0d b=%0d: avail=%b busy=%b product=%0d, want avail=1 busy=0 product=%0d",
                     tag, a, b, m8.AVAIL, m8.BUSY, m8.PRODUCT, exp);
        end
    endtask
    task automatic test_reset;
        #1 RST_N = 1'b0;
        #2 check_idle("reset_async");
        tick();
        tick();
        check_idle("reset_held");
        #2 RST_N = 1'b1;
        tick();
        tick();
        check_idle("reset_release_idle");
    endtask
    task automatic test_basic;
        run4(4'd3, 4'd5, 8'd15, "basic_3x5", 0);
    endtask
    task automatic test_avail_hold;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (m4.AVAIL !== 1'b1 || m4.BUSY !== 1'b0 || m4.PRODUCT !== 8'd15) begin
                errors++;
                $display("FAIL avail_hold%0d: avail=%b busy=%b product=%0d, want avail=1 busy=0 product=15",
                         i, m4.AVAIL, m4.BUSY, m4.PRODUCT);
            end
        end
    endtask
    task automatic test_extremes;
        run4(4'd15, 4'd15, 8'hE1, "max_15x15", 0);
        run4(4'd0, 4'd13, 8'd0, "zero_0x13", 0);
        run4(4'd9, 4'd0, 8'd0, "zero_9x0", 0);
        run4(4'd1, 4'd15, 8'd15, "one_1x15", 0);
    endtask
    task automatic test_back_to_back;
        run4(4'd7, 4'd9, 8'd63, "b2b_7x9", 2);
        run4(4'd12, 4'd11, 8'd132, "b2b_12x11", 2);
        m4.START = 1'b0;
        tick();
    endtask
    task automatic test_start_during_run;
        run4(4'd6, 4'd10, 8'd60, "start_in_run_6x10", 1);
        tick();
        checks++;
        if (m4.AVAIL !== 1'b1 || m4.PRODUCT !== 8'd60) begin
            errors++;
            $display("FAIL start_in_run_stay: avail=%b product=%0d, want avail=1 product=60", m4.AVAIL, m4.PRODUCT);
        end
    endtask
    task automatic test_async_reset;
        m4.START = 1'b1;
        m4.MULTIPLICAND = 4'd5;
        m4.MULTIPLIER = 4'd7;
        tick();
        m4.START = 1'b0;
        tick();
        #2 RST_N = 1'b0;
        #1 check_idle("rst_mid_run");
        #2 RST_N = 1'b1;
        tick();
        check_idle("rst_after_release0");
        tick();
        tick();
        check_idle("rst_after_release1");
        run4(4'd2, 4'd3, 8'd6, "rst_then_2x3", 0);
    endtask
    task automatic test_wl8;
        logic [7:0] a, b;
        run8(8'd255, 8'd255, 16'hFE01, "wl8_max");
        run8(8'd0, 8'd200, 16'd0, "wl8_zero");
        run8(8'd128, 8'd2, 16'd256, "wl8_128x2");
        for (int i = 0; i < 200; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            run8(a, b, {8'd0, a} * {8'd0, b}, "wl8_rand");
        end
    endtask
    initial begin
        m4.START = 1'b0;
        m4.MULTIPLICAND = '0;
        m4.MULTIPLIER = '0;
        m8.START = 1'b0;
        m8.MULTIPLICAND = '0;
        m8.MULTIPLIER = '0;
        test_reset();
        test_basic();
        test_avail_hold();
        test_extremes();
        test_back_to_back();
        test_start_during_run();
        test_async_reset();
        test_wl8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule
